dm_mc: RTL

//   Multi-cycle data memory for the MEM stage, replacing the single-cycle DM.

---
 rtl/dm_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dm_mc.sv
//==============================================================================
// Module      : dm_mc
// Description : Multi-cycle MEM-stage data memory with fixed-latency response,
//               byte/half/word access, error detection and post-reset clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dm_mc #(
    parameter int DEPTH    = 3072,
    parameter int LATENCY  = 2,
    parameter int CLEAR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_mem [DEPTH];
    logic [IDXW-1:0] r_clrIdx;
    logic [CNTW-1:0] r_cnt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;

    logic        w_accept;
    logic        w_exec;
    logic        w_opWe;
    logic [1:0]  w_opSize;
    logic        w_opSigned;
    logic [31:0] w_opAddr;
    logic [31:0] w_opWdata;
    logic [31:0] w_opPc;
    logic        w_err;
    logic [IDXW-1:0] w_idx;
    logic [31:0] w_oldWord;
    logic [31:0] w_merged;
    logic [31:0] w_loadData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    // With single-cycle latency the op executes on the accept edge itself,
    // so it operates directly on the live request instead of the latch.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_exec     = w_accept;
            assign w_opWe     = req_we;
            assign w_opSize   = req_size;
            assign w_opSigned = req_signed;
            assign w_opAddr   = req_addr;
            assign w_opWdata  = req_wdata;
            assign w_opPc     = req_pc;
        end else begin : g_latN
            assign w_exec     = (r_state == S_BUSY) && (r_cnt == '0);
            assign w_opWe     = r_we;
            assign w_opSize   = r_size;
            assign w_opSigned = r_signed;
            assign w_opAddr   = r_addr;
            assign w_opWdata  = r_wdata;
            assign w_opPc     = r_pc;
        end
    endgenerate

    assign w_err = (w_opSize == 2'd3)
                || ((w_opSize == 2'd1) && w_opAddr[0])
                || ((w_opSize == 2'd2) && (w_opAddr[1:0] != 2'b00))
                || ({2'b00, w_opAddr[31:2]} >= 32'(DEPTH));

    assign w_idx     = w_opAddr[IDXW+1:2];
    assign w_oldWord = r_mem[w_idx];
    assign w_byte    = w_oldWord[{w_opAddr[1:0], 3'b000} +: 8];
    assign w_half    = w_oldWord[{w_opAddr[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = w_oldWord;
        case (w_opSize)
            2'd0:    w_merged[{w_opAddr[1:0], 3'b000} +: 8] = w_opWdata[7:0];
            2'd1:    w_merged[{w_opAddr[1], 4'b0000} +: 16] = w_opWdata[15:0];
            default: w_merged = w_opWdata;
        endcase
    end

    always_comb begin
        w_loadData = w_oldWord;
        case (w_opSize)
            2'd0:    w_loadData = {{24{w_opSigned & w_byte[7]}}, w_byte};
            2'd1:    w_loadData = {{16{w_opSigned & w_half[15]}}, w_half};
            default: w_loadData = w_oldWord;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_CLEAR: if (r_clrIdx == IDXW'(DEPTH - 1)) w_nextState = S_IDLE;
            S_IDLE:  if (req_valid && (LATENCY > 1)) w_nextState = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clrIdx <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_clrIdx <= r_clrIdx + 1'b1;
            end
            if (w_accept) begin
                r_cnt    <= CNTW'(LATENCY - 2);
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_pc     <= req_pc;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Reset gates the write port so an op pending across reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clrIdx] <= '0;
            end else if (w_exec && w_opWe && !w_err) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= w_exec;
            if (w_exec) begin
                resp_err   <= w_err;
                resp_rdata <= (w_err || w_opWe) ? 32'h0 : w_loadData;
`ifndef SYNTHESIS
                if (w_opWe && !w_err) begin
                    $display("@%h: *%h <= %h", w_opPc, {w_opAddr[31:2], 2'b00}, w_merged);
                end
`endif
            end
        end
    end

endmodule

`default_nettype wire
